// File: rtl/align_shifter_pipe.sv
// Pipelined alignment/normalisation barrel shifter with valid/ready flow control.
// Produces the adjusted exponent plus sticky/lost/range/overflow flags that travel with each beat.
module align_shifter_pipe #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 28,
    parameter int REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             dir,
    input  logic             mode,
    input  logic [EXP_W-1:0] exp,
    input  logic [EXP_W-1:0] exp_target_or_diff,
    input  logic [MAN_W-1:0] mantis,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] mantis_out,
    output logic             sticky,
    output logic             lost,
    output logic             range_err,
    output logic             exp_ovf
);
    localparam int LEVELS = $clog2(MAN_W);

    // flag holds sticky (right shifts) or lost (left shifts); dir selects which output shows it
    typedef struct packed {
        logic              valid;
        logic              dir;
        logic              range_err;
        logic              exp_ovf;
        logic [EXP_W-1:0]  exp;
        logic [LEVELS-1:0] sh;
        logic [MAN_W-1:0]  mant;
        logic              flag;
    } beat_t;

    logic             advance;
    logic [EXP_W:0]   sh_full;
    logic [EXP_W:0]   e_full;
    logic             neg;
    logic [MAN_W-1:0] ones;
    beat_t            cap;
    beat_t            out_q;
    logic             unused_sh;

    assign ones     = '1;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Capture: shift amount and exponent in EXP_W+1 bits; oversize shifts resolve here
    // so the barrel only ever sees amounts below MAN_W.
    always_comb begin
        sh_full       = {1'b0, exp_target_or_diff};
        e_full        = '0;
        neg           = 1'b0;
        cap           = '0;
        cap.valid     = in_valid;
        cap.dir       = dir;
        if (!mode) begin
            if (!dir) begin
                e_full      = {1'b0, exp} + {1'b0, exp_target_or_diff};
                cap.exp_ovf = e_full[EXP_W];
            end else begin
                e_full      = {1'b0, exp} - {1'b0, exp_target_or_diff};
                cap.exp_ovf = (exp < exp_target_or_diff);
            end
        end else begin
            e_full = {1'b0, exp_target_or_diff};
            if (!dir) begin
                neg     = (exp_target_or_diff < exp);
                sh_full = {1'b0, exp_target_or_diff} - {1'b0, exp};
            end else begin
                neg     = (exp < exp_target_or_diff);
                sh_full = {1'b0, exp} - {1'b0, exp_target_or_diff};
            end
            if (neg) begin
                cap.range_err = 1'b1;
                sh_full       = '0;
                e_full        = {1'b0, exp};
            end
        end
        cap.exp  = e_full[EXP_W-1:0];
        cap.mant = mantis;
        if (32'(sh_full) >= 32'(MAN_W)) begin
            cap.mant = '0;
            cap.flag = |mantis;
            cap.sh   = '0;
        end else begin
            cap.sh   = sh_full[LEVELS-1:0];
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int SHIFT = 1 << k;
        localparam bit REG   = (REG_EVERY != 0) || (k == LEVELS - 1);
        beat_t d;
        beat_t s;
        beat_t q;

        if (k == 0) begin : g_src
            assign d = cap;
        end else begin : g_src
            assign d = g_lvl[k-1].q;
        end

        always_comb begin
            s = d;
            if (d.sh[k]) begin
                if (!d.dir) begin
                    s.flag = d.flag | (|(d.mant & ~(ones << SHIFT)));
                    s.mant = d.mant >> SHIFT;
                end else begin
                    s.flag = d.flag | (|(d.mant & ~(ones >> SHIFT)));
                    s.mant = d.mant << SHIFT;
                end
            end
        end

        // Every stage freezes together when downstream stalls
        if (REG) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (advance) begin
                    q <= s;
                end
            end
        end else begin : g_comb
            assign q = s;
        end
    end

    assign out_q      = g_lvl[LEVELS-1].q;
    assign out_valid  = out_q.valid;
    assign exp_out    = out_q.exp;
    assign mantis_out = out_q.mant;
    assign sticky     = out_q.flag & ~out_q.dir;
    assign lost       = out_q.flag & out_q.dir;
    assign range_err  = out_q.range_err;
    assign exp_ovf    = out_q.exp_ovf;
    assign unused_sh  = ^out_q.sh;
endmodule

// File: tb/tb_align_shifter_pipe.sv
// Randomised scoreboard bench for align_shifter_pipe against an arithmetic reference model.
module tb_align_shifter_pipe;
    localparam int EXP_W     = 8;
    localparam int MAN_W     = 28;
    localparam int REG_EVERY = 1;
    localparam int LEVELS    = $clog2(MAN_W);
    localparam int LAT       = (REG_EVERY != 0) ? LEVELS : 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             dir = 1'b0;
    logic             mode = 1'b0;
    logic [EXP_W-1:0] exp = '0;
    logic [EXP_W-1:0] exp_target_or_diff = '0;
    logic [MAN_W-1:0] mantis = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [EXP_W-1:0] exp_out;
    logic [MAN_W-1:0] mantis_out;
    logic             sticky;
    logic             lost;
    logic             range_err;
    logic             exp_ovf;

    typedef struct {
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic             st;
        logic             lo;
        logic             re;
        logic             ov;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_ready = 1'b0;
    int   stall_left = 0;

    align_shifter_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .REG_EVERY(REG_EVERY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dir(dir), .mode(mode), .exp(exp), .exp_target_or_diff(exp_target_or_diff),
        .mantis(mantis), .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .mantis_out(mantis_out), .sticky(sticky), .lost(lost),
        .range_err(range_err), .exp_ovf(exp_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on exponent and a wide mantissa
    function automatic exp_t model(input bit d, input bit m, input int ex, input int td,
                                   input logic [MAN_W-1:0] man);
        exp_t r;
        int e, sh;
        logic [63:0] m64;
        bit flag;
        m64 = 64'(man);
        r.re = 1'b0;
        if (!m) begin
            sh = td;
            e  = d ? ex - td : ex + td;
        end else begin
            sh = d ? ex - td : td - ex;
            e  = td;
        end
        if (m && sh < 0) begin
            r.re = 1'b1;
            sh   = 0;
            e    = ex;
        end
        r.ov = (e < 0) || (e > (1 << EXP_W) - 1);
        r.e  = EXP_W'(e);
        if (sh >= MAN_W) begin
            r.m  = '0;
            flag = (man != 0);
        end else if (!d) begin
            r.m  = MAN_W'(m64 >> sh);
            flag = ((m64 & ((64'd1 << sh) - 64'd1)) != 0);
        end else begin
            r.m  = MAN_W'(m64 << sh);
            flag = ((m64 >> (MAN_W - sh)) != 0);
        end
        r.st = flag && !d;
        r.lo = flag && d;
        return r;
    endfunction

    task automatic stepCycle(input bit v, input bit d, input bit m, input logic [EXP_W-1:0] e,
                             input logic [EXP_W-1:0] t, input logic [MAN_W-1:0] man, output bit acc);
        @(negedge clk);
        in_valid = v; dir = d; mode = m; exp = e; exp_target_or_diff = t; mantis = man;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        #1;
        acc = v && in_ready;
        if (acc) sb.push_back(model(d, m, int'(e), int'(t), man));
    endtask

    task automatic applyStimulus(input bit d, input bit m, input logic [EXP_W-1:0] e,
                                 input logic [EXP_W-1:0] t, input logic [MAN_W-1:0] man);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            stepCycle(1'b1, d, m, e, t, man, acc);
            tries++;
        end
        if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) stepCycle(1'b0, 1'b0, 1'b0, '0, '0, '0, acc);
    endtask

    task automatic measureLatency(input string name);
        int lat;
        applyStimulus(1'b0, 1'b0, 8'h10, 8'h02, 28'h000000F);
        lat = 1;
        idle(1);
        while (!out_valid && lat < 20) begin
            lat++;
            idle(1);
        end
        checkOutput(name, 64'(lat), 64'(LAT));
    endtask

    // Monitor: pops on each output handshake, checks hold-during-stall and the ready rule
    logic [63:0] snap;
    bit          prev_stall = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (prev_stall)
                checkOutput("hold", {24'd0, exp_out, mantis_out, sticky, lost, range_err, exp_ovf}, snap);
            checkOutput("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    checkOutput("exp_out", 64'(exp_out), 64'(x.e));
                    checkOutput("mantis_out", 64'(mantis_out), 64'(x.m));
                    checkOutput("flags", {60'd0, sticky, lost, range_err, exp_ovf},
                                {60'd0, x.st, x.lo, x.re, x.ov});
                end
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        snap = {24'd0, exp_out, mantis_out, sticky, lost, range_err, exp_ovf};
    end

    initial begin
        int waitc;
        #12;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_outputs", {24'd0, exp_out, mantis_out, sticky, lost, range_err, exp_ovf}, 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        measureLatency("latency");

        applyStimulus(1'b0, 1'b0, 8'h10, 8'h02, 28'h000000F);
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h04, 28'h0000001);
        applyStimulus(1'b0, 1'b0, 8'h10, 8'd40, 28'h8000000);
        applyStimulus(1'b0, 1'b0, 8'h20, 8'hF0, 28'h8000000);
        applyStimulus(1'b0, 1'b1, 8'h03, 8'h05, 28'h0000004);
        applyStimulus(1'b0, 1'b1, 8'h05, 8'h03, 28'h0ABCDEF);
        applyStimulus(1'b1, 1'b1, 8'h09, 8'h01, 28'h0F00001);
        applyStimulus(1'b1, 1'b0, 8'h02, 8'h1C, 28'h0000003);
        applyStimulus(1'b1, 1'b0, 8'h30, 8'd27, 28'h0000001);
        applyStimulus(1'b0, 1'b0, 8'hFF, 8'h00, 28'hFFFFFFF);
        idle(LAT + 2);

        // Eight back-to-back beats with a three-cycle stall once the pipeline has filled
        for (int i = 0; i < 8; i++) begin
            if (i == LAT) stall_left = 3;
            applyStimulus(i[0], 1'b0, 8'(8'h40 + i), 8'(i * 3), 28'($urandom));
        end
        idle(LAT + 6);
        checkOutput("stall_drain", 64'(sb.size()), 64'd0);

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h11, 8'(i + 1), 28'h0FFFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        sb.delete();
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_outputs", {24'd0, exp_out, mantis_out, sticky, lost, range_err, exp_ovf}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(LAT + 3);
        measureLatency("latency_after_reset");

        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [EXP_W-1:0] e, t;
            e = 8'($urandom);
            t = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1 && i[2]) t = 8'(int'(e) + $urandom_range(0, 20) - 10);
            applyStimulus(1'($urandom), 1'($urandom), e, t, 28'($urandom));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end

        rand_ready = 1'b0;
        waitc = 0;
        while (sb.size() != 0 && waitc < 300) begin
            idle(1);
            waitc++;
        end
        checkOutput("final_drain", 64'(sb.size()), 64'd0);
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
